// File: rtl/mem_access.sv
// mem_access: load/store bus stage with byte strobes and load extension; MEM_TIMEOUT_EN adds a REQ ack timeout
module mem_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        fault,
    output logic        stall
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, ld_val;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d, fault_q, fault_d;
    logic        start, illegal, misaligned, timeout_hit;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign start      = mem_rd | mem_wr;
    assign illegal    = mem_wr ? (funct3 > 3'd2) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    assign misaligned = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign ld_b       = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign ld_h       = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    assign ld_val     = f3_q[1] ? bus_rdata :
                        f3_q[0] ? {{16{~f3_q[2] & ld_h[15]}}, ld_h} :
                                  {{24{~f3_q[2] & ld_b[7]}}, ld_b};

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    assign cnt_d       = (state_q == REQ) ? cnt_q + 8'd1 : 8'd0;
    assign timeout_hit = (state_q == REQ) && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk) cnt_q <= rst ? 8'd0 : cnt_d;
`else
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        f3_d    = f3_q;
        we_d    = we_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (start) begin
                addr_d  = addr;
                f3_d    = funct3;
                we_d    = mem_wr;
                fault_d = illegal | misaligned;
                wdata_d = funct3[1] ? wdata : funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
                wstrb_d = !mem_wr ? 4'b0000 : funct3[1] ? 4'b1111 :
                          funct3[0] ? (4'b0011 << addr[1:0]) : (4'b0001 << addr[1:0]);
                state_d = (illegal | misaligned) ? RESP : REQ;
            end
            REQ: if (bus_ack) begin
                rdata_d = we_q ? rdata_q : ld_val;
                state_d = RESP;
            end else if (timeout_hit) begin
                fault_d = 1'b1;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus_req   = state_q == REQ;
    assign bus_we    = bus_req & we_q;
    assign bus_wstrb = bus_req ? wstrb_q : 4'b0000;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign done      = state_q == RESP;
    assign fault     = done & fault_q;
    assign stall     = bus_req | (state_q == IDLE && start);
endmodule
